// File: rtl/dispatch_queue_if.sv
// Issue-side bundle for the dispatch queue: decoded-op enqueue handshake,
// per-channel dispatch request/accept, shared head payload and status.
// slave = queue side, master = producer/consumer side.
interface dispatch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 5,
    parameter int GRP_W  = 3,
    parameter int INFO_W = 32
);
    logic                     flush_i;
    logic                     enq_valid_i;
    logic                     enq_ready_o;
    logic [GRP_W-1:0]         enq_grp_i;
    logic [INFO_W-1:0]        enq_info_i;
    logic [31:0]              enq_pc_i;
    logic [31:0]              enq_imm_i;
    logic [31:0]              enq_op1_i;
    logic [31:0]              enq_op2_i;
    logic [NUM_CH-1:0]        ch_valid_o;
    logic [NUM_CH-1:0]        ch_ready_i;
    logic [GRP_W-1:0]         deq_grp_o;
    logic [INFO_W-1:0]        deq_info_o;
    logic [31:0]              deq_pc_o;
    logic [31:0]              deq_imm_o;
    logic [31:0]              deq_op1_o;
    logic [31:0]              deq_op2_o;
    logic                     illegal_o;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     empty_o;
    logic                     full_o;

    modport slave (
        input  flush_i, enq_valid_i, enq_grp_i, enq_info_i, enq_pc_i, enq_imm_i,
               enq_op1_i, enq_op2_i, ch_ready_i,
        output enq_ready_o, ch_valid_o, deq_grp_o, deq_info_o, deq_pc_o, deq_imm_o,
               deq_op1_o, deq_op2_o, illegal_o, count_o, empty_o, full_o
    );

    modport master (
        output flush_i, enq_valid_i, enq_grp_i, enq_info_i, enq_pc_i, enq_imm_i,
               enq_op1_i, enq_op2_i, ch_ready_i,
        input  enq_ready_o, ch_valid_o, deq_grp_o, deq_info_o, deq_pc_o, deq_imm_o,
               deq_op1_o, deq_op2_o, illegal_o, count_o, empty_o, full_o
    );
endinterface

// File: rtl/dispatch_queue.sv
// Purpose: in-order decoded-op queue steering the head op to one functional-unit channel.
// Latency: 1 cycle enqueue-to-head; 0 cycles on an empty queue when BYPASS=1.
// Backpressure: enq_ready_o = !full only; head request held until its channel accepts.
module dispatch_queue #(
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 5,
    parameter int GRP_W  = 3,
    parameter int INFO_W = 32,
    parameter int BYPASS = 0
) (
    input logic           clk,
    input logic           rst_n,
    dispatch_queue_if.slave dq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [GRP_W:0] NUM_CH_L = (GRP_W+1)'(NUM_CH);

    typedef struct packed {
        logic [GRP_W-1:0]  grp;
        logic [INFO_W-1:0] info;
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [31:0]       op1;
        logic [31:0]       op2;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    entry_t            head;
    entry_t            enq_ent;
    entry_t            deq_ent;
    logic              empty;
    logic              full;
    logic              head_legal;
    logic              enq_legal;
    logic              byp;
    logic              illegal;
    logic              deq_fire;
    logic              pop;
    logic              push;
    logic [NUM_CH-1:0] ch_valid;

    function automatic logic [NUM_CH-1:0] onehot(input logic [GRP_W-1:0] g);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v[k] = ({1'b0, g} == (GRP_W+1)'(k));
        end
        return v;
    endfunction

    assign enq_ent = '{grp: dq.enq_grp_i, info: dq.enq_info_i, pc: dq.enq_pc_i,
                       imm: dq.enq_imm_i, op1: dq.enq_op1_i, op2: dq.enq_op2_i};
    assign head       = mem[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign head_legal = ({1'b0, head.grp} < NUM_CH_L);
    assign enq_legal  = ({1'b0, dq.enq_grp_i} < NUM_CH_L);

    // Pass-through only for a legal op into an empty queue; illegal ops take the stored path.
    assign byp = (BYPASS != 0) && rst_n && !dq.flush_i && empty && dq.enq_valid_i && enq_legal;

    always_comb begin
        ch_valid = '0;
        deq_ent  = '0;
        if (!empty) begin
            deq_ent = head;
        end else if (byp) begin
            deq_ent = enq_ent;
        end
        if (rst_n && !dq.flush_i) begin
            if (!empty && head_legal) begin
                ch_valid = onehot(head.grp);
            end else if (byp) begin
                ch_valid = onehot(dq.enq_grp_i);
            end
        end
    end

    assign illegal  = rst_n && !dq.flush_i && !empty && !head_legal;
    assign deq_fire = |(ch_valid & dq.ch_ready_i);
    assign pop      = !empty && (deq_fire || illegal);
    // A bypassed op that is accepted never touches storage.
    assign push     = rst_n && dq.enq_valid_i && !full && !dq.flush_i && !(byp && deq_fire);

    always_ff @(posedge clk) begin
        if (!rst_n || dq.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enq_ent;
    end

    assign dq.enq_ready_o = !full;
    assign dq.ch_valid_o  = ch_valid;
    assign dq.illegal_o   = illegal;
    assign dq.deq_grp_o   = deq_ent.grp;
    assign dq.deq_info_o  = deq_ent.info;
    assign dq.deq_pc_o    = deq_ent.pc;
    assign dq.deq_imm_o   = deq_ent.imm;
    assign dq.deq_op1_o   = deq_ent.op1;
    assign dq.deq_op2_o   = deq_ent.op2;
    assign dq.count_o     = count;
    assign dq.empty_o     = empty;
    assign dq.full_o      = full;
endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed vector table on the BYPASS=0 instance, a bypass
// sequence on the BYPASS=1 instance, then random traffic on both against a queue model.
`timescale 1ns/1ps
module tb_dispatch_queue;
    localparam int DEPTH  = 4;
    localparam int NUM_CH = 5;
    localparam int GRP_W  = 3;
    localparam int INFO_W = 32;

    typedef struct packed {
        logic [2:0]  grp;
        logic [31:0] info;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] op1;
        logic [31:0] op2;
    } ent_t;

    typedef struct {
        bit          rst_n;
        bit          flush;
        bit          ev;
        logic [2:0]  grp;
        logic [31:0] pc;
        logic [4:0]  rdy;
        logic [4:0]  e_vld;
        bit          e_ill;
        int          e_cnt;
        logic [31:0] e_pc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        d_rst_n, d_flush, d_ev;
    logic [2:0]  d_grp;
    logic [31:0] d_info, d_pc, d_imm, d_op1, d_op2;
    logic [4:0]  d_rdy;

    int errors = 0;
    int checks = 0;
    vec_t tv[$];
    ent_t mq0[$];
    ent_t mq1[$];

    dispatch_queue_if #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .GRP_W(GRP_W), .INFO_W(INFO_W)) if0 ();
    dispatch_queue_if #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .GRP_W(GRP_W), .INFO_W(INFO_W)) if1 ();

    assign if0.flush_i = d_flush;   assign if1.flush_i = d_flush;
    assign if0.enq_valid_i = d_ev;  assign if1.enq_valid_i = d_ev;
    assign if0.enq_grp_i = d_grp;   assign if1.enq_grp_i = d_grp;
    assign if0.enq_info_i = d_info; assign if1.enq_info_i = d_info;
    assign if0.enq_pc_i = d_pc;     assign if1.enq_pc_i = d_pc;
    assign if0.enq_imm_i = d_imm;   assign if1.enq_imm_i = d_imm;
    assign if0.enq_op1_i = d_op1;   assign if1.enq_op1_i = d_op1;
    assign if0.enq_op2_i = d_op2;   assign if1.enq_op2_i = d_op2;
    assign if0.ch_ready_i = d_rdy;  assign if1.ch_ready_i = d_rdy;

    dispatch_queue #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .GRP_W(GRP_W), .INFO_W(INFO_W), .BYPASS(0))
        u_dq0 (.clk(clk), .rst_n(d_rst_n), .dq(if0.slave));
    dispatch_queue #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .GRP_W(GRP_W), .INFO_W(INFO_W), .BYPASS(1))
        u_dq1 (.clk(clk), .rst_n(d_rst_n), .dq(if1.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit rst_n, input bit flush, input bit ev, input logic [2:0] grp,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rdy);
        d_rst_n = rst_n; d_flush = flush; d_ev = ev; d_grp = grp;
        d_pc = pc; d_imm = imm; d_op1 = ~pc; d_op2 = pc ^ 32'h5A5A_0000;
        d_info = 32'hA000_0000 | pc; d_rdy = rdy;
    endtask

    task automatic add(input bit rst_n, input bit flush, input bit ev, input logic [2:0] grp,
                       input logic [31:0] pc, input logic [4:0] rdy, input logic [4:0] e_vld,
                       input bit e_ill, input int e_cnt, input logic [31:0] e_pc);
        tv.push_back('{rst_n, flush, ev, grp, pc, rdy, e_vld, e_ill, e_cnt, e_pc});
    endtask

    // Queue-level reference: checks DUT b against the model, then advances the model one cycle.
    task automatic model_step(input int b, input int cyc);
        ent_t q[$];
        ent_t inp, e_deq;
        logic [4:0] e_vld, a_vld;
        logic e_ill, a_ill, a_rdy, a_emp, a_full, byp, fire, pop, push;
        logic [3:0] a_cnt;
        logic [31:0] a_pc, a_imm, a_op2;
        logic [34:0] a_gi;
        int sz;
        string tag;
        if (b == 0) q = mq0; else q = mq1;
        if (b == 0) begin
            a_vld = if0.ch_valid_o; a_ill = if0.illegal_o; a_rdy = if0.enq_ready_o;
            a_emp = if0.empty_o; a_full = if0.full_o; a_cnt = if0.count_o;
            a_pc = if0.deq_pc_o; a_imm = if0.deq_imm_o; a_op2 = if0.deq_op2_o;
            a_gi = {if0.deq_grp_o, if0.deq_info_o};
        end else begin
            a_vld = if1.ch_valid_o; a_ill = if1.illegal_o; a_rdy = if1.enq_ready_o;
            a_emp = if1.empty_o; a_full = if1.full_o; a_cnt = if1.count_o;
            a_pc = if1.deq_pc_o; a_imm = if1.deq_imm_o; a_op2 = if1.deq_op2_o;
            a_gi = {if1.deq_grp_o, if1.deq_info_o};
        end
        tag = $sformatf("rnd c%0d dut%0d", cyc, b);
        sz = q.size();
        inp = '{d_grp, d_info, d_pc, d_imm, d_op1, d_op2};
        byp = (b == 1) && (sz == 0) && d_ev && (d_grp < 5) && d_rst_n && !d_flush;
        e_vld = '0; e_ill = 1'b0; e_deq = '0;
        if (sz > 0) e_deq = q[0];
        else if (byp) e_deq = inp;
        if (d_rst_n && !d_flush) begin
            if (sz > 0) begin
                if (q[0].grp < 5) e_vld = 5'b00001 << q[0].grp;
                else e_ill = 1'b1;
            end else if (byp) begin
                e_vld = 5'b00001 << d_grp;
            end
        end
        chk({tag, " ch_valid"}, 64'(a_vld), 64'(e_vld));
        chk({tag, " illegal"}, 64'(a_ill), 64'(e_ill));
        chk({tag, " count"}, 64'(a_cnt), 64'(sz));
        chk({tag, " enq_ready"}, 64'(a_rdy), 64'(sz < DEPTH));
        chk({tag, " empty"}, 64'(a_emp), 64'(sz == 0));
        chk({tag, " full"}, 64'(a_full), 64'(sz == DEPTH));
        if (d_rst_n && !d_flush) begin
            chk({tag, " deq_pc"}, 64'(a_pc), 64'(e_deq.pc));
            chk({tag, " deq_imm"}, 64'(a_imm), 64'(e_deq.imm));
            chk({tag, " deq_op2"}, 64'(a_op2), 64'(e_deq.op2));
            chk({tag, " deq_grp_info"}, 64'(a_gi), 64'({e_deq.grp, e_deq.info}));
        end
        if (!d_rst_n || d_flush) begin
            q.delete();
        end else begin
            fire = ((e_vld & d_rdy) != 5'b0);
            pop  = (sz > 0) && (fire || e_ill);
            push = d_ev && (sz < DEPTH) && !((sz == 0) && fire);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(inp);
        end
        if (b == 0) mq0 = q; else mq1 = q;
    endtask

    initial begin
        drv(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'b0);
        tick(); tick();

        //   rst flush ev grp  pc          rdy       e_vld     ill cnt e_pc
        add(1, 0, 0, 3'd0, 32'h000, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 1, 3'd0, 32'h100, 5'b00001, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 0, 3'd0, 32'h000, 5'b00001, 5'b00001, 0, 1, 32'h100);
        add(1, 0, 0, 3'd0, 32'h000, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 1, 3'd0, 32'h200, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 1, 3'd1, 32'h204, 5'b00000, 5'b00001, 0, 1, 32'h200);
        add(1, 0, 1, 3'd2, 32'h208, 5'b00000, 5'b00001, 0, 2, 32'h200);
        add(1, 0, 1, 3'd3, 32'h20C, 5'b00000, 5'b00001, 0, 3, 32'h200);
        add(1, 0, 1, 3'd4, 32'h210, 5'b00000, 5'b00001, 0, 4, 32'h200);
        add(1, 0, 1, 3'd4, 32'h210, 5'b11111, 5'b00001, 0, 4, 32'h200);
        add(1, 0, 0, 3'd0, 32'h000, 5'b11111, 5'b00010, 0, 3, 32'h204);
        add(1, 0, 0, 3'd0, 32'h000, 5'b11111, 5'b00100, 0, 2, 32'h208);
        add(1, 0, 0, 3'd0, 32'h000, 5'b11111, 5'b01000, 0, 1, 32'h20C);
        add(1, 0, 0, 3'd0, 32'h000, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 1, 3'd4, 32'h300, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 0, 3'd0, 32'h000, 5'b01111, 5'b10000, 0, 1, 32'h300);
        add(1, 0, 0, 3'd0, 32'h000, 5'b01111, 5'b10000, 0, 1, 32'h300);
        add(1, 0, 0, 3'd0, 32'h000, 5'b01111, 5'b10000, 0, 1, 32'h300);
        add(1, 0, 0, 3'd0, 32'h000, 5'b10000, 5'b10000, 0, 1, 32'h300);
        add(1, 0, 0, 3'd0, 32'h000, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 1, 3'd7, 32'h400, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 1, 3'd2, 32'h404, 5'b00000, 5'b00000, 1, 1, 32'h400);
        add(1, 0, 0, 3'd0, 32'h000, 5'b00000, 5'b00100, 0, 1, 32'h404);
        add(1, 0, 0, 3'd0, 32'h000, 5'b00100, 5'b00100, 0, 1, 32'h404);
        add(1, 0, 0, 3'd0, 32'h000, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 1, 3'd0, 32'h500, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 1, 3'd1, 32'h504, 5'b00000, 5'b00001, 0, 1, 32'h500);
        add(1, 0, 1, 3'd2, 32'h508, 5'b00000, 5'b00001, 0, 2, 32'h500);
        add(1, 1, 1, 3'd3, 32'h50C, 5'b11111, 5'b00000, 0, 3, 32'h000);
        add(1, 0, 0, 3'd0, 32'h000, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(1, 0, 1, 3'd0, 32'h600, 5'b00000, 5'b00000, 0, 0, 32'h000);
        add(0, 0, 1, 3'd1, 32'h604, 5'b11111, 5'b00000, 0, 1, 32'h000);
        add(1, 0, 0, 3'd0, 32'h000, 5'b00000, 5'b00000, 0, 0, 32'h000);

        foreach (tv[i]) begin
            drv(tv[i].rst_n, tv[i].flush, tv[i].ev, tv[i].grp, tv[i].pc, tv[i].pc + 32'd4, tv[i].rdy);
            #1;
            chk($sformatf("tv%0d ch_valid", i), 64'(if0.ch_valid_o), 64'(tv[i].e_vld));
            chk($sformatf("tv%0d illegal", i), 64'(if0.illegal_o), 64'(tv[i].e_ill));
            chk($sformatf("tv%0d count", i), 64'(if0.count_o), 64'(tv[i].e_cnt));
            chk($sformatf("tv%0d enq_ready", i), 64'(if0.enq_ready_o), 64'(tv[i].e_cnt != DEPTH));
            chk($sformatf("tv%0d empty", i), 64'(if0.empty_o), 64'(tv[i].e_cnt == 0));
            chk($sformatf("tv%0d full", i), 64'(if0.full_o), 64'(tv[i].e_cnt == DEPTH));
            if (tv[i].rst_n && !tv[i].flush) begin
                chk($sformatf("tv%0d deq_pc", i), 64'(if0.deq_pc_o), 64'(tv[i].e_pc));
                if (tv[i].e_vld != 5'b0)
                    chk($sformatf("tv%0d deq_imm", i), 64'(if0.deq_imm_o), 64'(tv[i].e_pc + 32'd4));
            end
            tick();
        end

        // Bypass instance: accepted pass-through, stalled pass-through, illegal on empty.
        drv(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'b0);
        tick();
        drv(1, 0, 1, 3'd1, 32'h700, 32'h4, 5'b00010); #1;
        chk("byp ch_valid", 64'(if1.ch_valid_o), 64'(5'b00010));
        chk("byp deq_imm", 64'(if1.deq_imm_o), 64'h4);
        chk("byp count", 64'(if1.count_o), 64'd0);
        tick();
        drv(1, 0, 0, 3'd0, 32'h0, 32'h0, 5'b00000); #1;
        chk("byp after count", 64'(if1.count_o), 64'd0);
        chk("byp after ch_valid", 64'(if1.ch_valid_o), 64'd0);
        chk("byp after deq_imm", 64'(if1.deq_imm_o), 64'd0);
        tick();
        drv(1, 0, 1, 3'd1, 32'h704, 32'h8, 5'b00000); #1;
        chk("byp stall ch_valid", 64'(if1.ch_valid_o), 64'(5'b00010));
        chk("byp stall deq_imm", 64'(if1.deq_imm_o), 64'h8);
        tick();
        drv(1, 0, 0, 3'd0, 32'h0, 32'h0, 5'b00000); #1;
        chk("byp stored count", 64'(if1.count_o), 64'd1);
        chk("byp stored ch_valid", 64'(if1.ch_valid_o), 64'(5'b00010));
        chk("byp stored deq_imm", 64'(if1.deq_imm_o), 64'h8);
        tick();
        drv(1, 0, 0, 3'd0, 32'h0, 32'h0, 5'b00010); #1;
        tick();
        drv(1, 0, 1, 3'd6, 32'h708, 32'hC, 5'b11111); #1;
        chk("byp illegal ch_valid", 64'(if1.ch_valid_o), 64'd0);
        chk("byp illegal pulse early", 64'(if1.illegal_o), 64'd0);
        chk("byp illegal count0", 64'(if1.count_o), 64'd0);
        tick();
        drv(1, 0, 0, 3'd0, 32'h0, 32'h0, 5'b11111); #1;
        chk("byp illegal pulse", 64'(if1.illegal_o), 64'd1);
        chk("byp illegal count1", 64'(if1.count_o), 64'd1);
        chk("byp illegal ch_valid2", 64'(if1.ch_valid_o), 64'd0);
        tick();
        #1;
        chk("byp illegal dropped", 64'(if1.count_o), 64'd0);
        chk("byp illegal one-shot", 64'(if1.illegal_o), 64'd0);

        // Random traffic on both instances against the queue model.
        drv(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'b0);
        tick();
        mq0.delete();
        mq1.delete();
        for (int c = 0; c < 3000; c++) begin
            d_rst_n = ($urandom_range(0, 99) != 0);
            d_flush = ($urandom_range(0, 19) == 0);
            d_ev    = ($urandom_range(0, 2) != 0);
            d_grp   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            d_info  = $urandom; d_pc = $urandom; d_imm = $urandom;
            d_op1   = $urandom; d_op2 = $urandom;
            d_rdy   = 5'($urandom);
            #1;
            model_step(0, c);
            model_step(1, c);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-002 Parameter NUM_CH, default 5, functional-unit channel count (ALU, BJP, MULDIV, CSR, MEM order by index).
REQ-003 Parameter GRP_W, default 3, group/channel-select width; 2^GRP_W >= NUM_CH.
REQ-004 Parameter INFO_W, default 32, opaque decode-info payload width.
REQ-005 Parameter BYPASS, default 0; 1 enables empty-queue pass-through.
REQ-006 Clock and reset are fixed: single clock clk; reset rst_n, synchronous, active-low.
REQ-007 clk  in  1  clock, all state updates on rising edge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 flush_i  in  1  discard all queued entries (pipeline redirect).
REQ-010 enq_valid_i  in  1  decoded op offered.
REQ-011 enq_ready_o  out  1  queue can accept; equals !full.
REQ-012 enq_grp_i  in  GRP_W  target channel index.
REQ-013 enq_info_i  in  INFO_W  decode info payload.
REQ-014 enq_pc_i, enq_imm_i, enq_op1_i, enq_op2_i  in  32 each  pc, immediate, rs1 data, rs2 data.
REQ-015 ch_valid_o  out  NUM_CH  one-hot request to the head entry's target channel.
REQ-016 ch_ready_i  in  NUM_CH  per-channel accept.
REQ-017 deq_grp_o, deq_info_o, deq_pc_o, deq_imm_o, deq_op1_o, deq_op2_o  out  GRP_W/INFO_W/32/32/32/32  head payload, shared by all channels.
REQ-018 illegal_o  out  1  one-cycle pulse: head entry with grp >= NUM_CH dropped.
REQ-019 count_o  out  $clog2(DEPTH)+1  valid entries held.
REQ-020 empty_o, full_o  out  1 each  count_o==0, count_o==DEPTH.

Function
REQ-021 Storage: circular buffer, write/read pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0; count tracked separately.
REQ-022 Enqueue fire = enq_valid_i & enq_ready_o & !flush_i; entry written at write pointer, visible at head next cycle (BYPASS=0 latency 1 cycle).
REQ-023 enq_ready_o depends only on full_o, never on ch_ready_i or flush_i; full queue with same-cycle dequeue still refuses enqueue.
REQ-024 Head legal (grp < NUM_CH) and !empty and !flush_i: ch_valid_o[grp]=1, all other bits 0.
REQ-025 Dequeue fire = ch_valid_o[k] & ch_ready_i[k]; read pointer advances, count decrements next cycle.
REQ-026 ch_valid_o held and deq_* stable until fire; ch_ready_i bits of non-targeted channels ignored.
REQ-027 Head illegal and !flush_i: ch_valid_o=0, illegal_o=1 for that cycle, entry popped unconditionally.
REQ-028 Simultaneous enqueue and dequeue fire: count unchanged, both pointers advance.
REQ-029 flush_i=1: ch_valid_o=0 and illegal_o=0 same cycle; next cycle pointers=0, count=0; concurrent enqueue discarded.
REQ-030 BYPASS=1 and queue empty and enq_valid_i and legal enq_grp_i: ch_valid_o and deq_* driven combinationally from enq_* inputs; if target ready, op consumed without being written and count stays 0; otherwise written normally.
REQ-031 BYPASS=1 with illegal enq_grp_i on empty queue: no bypass; entry written and dropped per REQ-027 next cycle.
REQ-032 Empty queue, no bypass: ch_valid_o=0, deq_* = 0.

Reset
REQ-033 rst_n low at clock edge: pointers=0, count_o=0, empty_o=1, full_o=0, enq_ready_o=1, ch_valid_o=0, illegal_o=0, deq_*=0; storage contents need not reset.
REQ-034 rst_n dominates flush_i and enqueue; in-flight head request abandoned without fire.

Verification
REQ-035 DEPTH=4, BYPASS=0: enqueue grp=0 pc=0x100, ch_ready_i=5'b00001 -> next cycle ch_valid_o=5'b00001, deq_pc_o=0x100, following cycle empty_o=1.
REQ-036 Fill 4 entries, ch_ready_i=0 -> full_o=1, enq_ready_o=0, count_o=4; fifth offer not accepted; release ready -> entries out in order, pointers wrap, count 3,2,1,0.
REQ-037 Head grp=4 (MEM) with ch_ready_i[4]=0 for 3 cycles -> ch_valid_o=5'b10000 and deq_* constant all 3 cycles; ready[0..3]=1 has no effect.
REQ-038 Enqueue grp=7 (NUM_CH=5) -> one illegal_o pulse, ch_valid_o=0, entry removed, next entry dispatched following cycle.
REQ-039 Queue count=3, flush_i with enq_valid_i=1 -> same cycle ch_valid_o=0; next cycle count_o=0, empty_o=1, enqueued op absent.
REQ-040 BYPASS=1, empty, enq grp=1 imm=0x4, ch_ready_i[1]=1 -> same-cycle ch_valid_o=5'b00010, deq_imm_o=0x4, count_o remains 0.
